// File: rtl/ss_stage_seq.sv
// ss_stage_seq: stage sequencer for the memory-based 8-point DCT datapath.
// On start it runs STAGES passes over an N-word ping-pong memory block.
// Each pass reads one bank, shifts every word left by that stage's amount
// and writes the result to the other bank at the same index.
// Optional feature: define SS_SAT_EN to clamp out-of-range results and raise
// a sticky ovf flag. Without it results wrap and ovf is tied to 0.
module ss_stage_seq #(
  parameter int WIDTH  = 16,
  parameter int N      = 8,
  parameter int ADDR_W = 3,
  parameter int STAGES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*STAGES-1:0] cfg_shift,
  output logic                busy,
  output logic                done,
  output logic [2:0]          stage_idx,
  output logic                result_bank,
  output logic                mem_rd_en,
  output logic [ADDR_W:0]     mem_rd_addr,
  input  logic [WIDTH-1:0]    mem_rd_data,
  output logic                mem_wr_en,
  output logic [ADDR_W:0]     mem_wr_addr,
  output logic [WIDTH-1:0]    mem_wr_data,
  output logic                ovf
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state;
  logic [2*STAGES-1:0] shift_cfg;
  logic                drain_cnt;
  logic [2:0]          stage_nxt;
  logic                start_acc;

  // Read-issue side: shift travels with each read strobe
  logic [1:0]          shift_p0;

  // Data-return side: metadata aligned with mem_rd_data
  logic                vld_p1;
  logic [ADDR_W-1:0]   idx_p1;
  logic                bank_p1;
  logic [1:0]          shift_p1;

`ifdef SS_SAT_EN
  // Sign-extend by 3 bits so a shift of up to 3 cannot lose information.
  function automatic logic signed [WIDTH+2:0] shift_ext(input logic signed [WIDTH-1:0] din,
                                                         input logic [1:0] sh);
    logic signed [WIDTH+2:0] ext;
    ext = {{3{din[WIDTH-1]}}, din};
    return ext <<< sh;
  endfunction

  // True when the top bits are pure sign extension, i.e. the value fits WIDTH.
  function automatic logic fits(input logic signed [WIDTH+2:0] v);
    return (v[WIDTH+2:WIDTH-1] == '0) || (v[WIDTH+2:WIDTH-1] == '1);
  endfunction

  function automatic logic sat_hit(input logic signed [WIDTH-1:0] din, input logic [1:0] sh);
    return !fits(shift_ext(din, sh));
  endfunction

  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] din,
                                                    input logic [1:0] sh);
    logic signed [WIDTH+2:0] v;
    v = shift_ext(din, sh);
    if (fits(v))
      return v[WIDTH-1:0];
    else if (v[WIDTH+2])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`else
  // Wrapping shift: low WIDTH bits kept.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] din,
                                                    input logic [1:0] sh);
    return din <<< sh;
  endfunction
`endif

  assign stage_nxt = stage_idx + 3'd1;
  assign start_acc = (state == IDLE) && start;

  // Control FSM: sequences reads, drains the write pipe, advances stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_cfg   <= '0;
      drain_cnt   <= 1'b0;
      stage_idx   <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_bank <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      shift_p0    <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            shift_cfg   <= cfg_shift;
            stage_idx   <= 3'd0;
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= {1'b0, {ADDR_W{1'b0}}};
            shift_p0    <= cfg_shift[1:0];
            state       <= READ;
          end
        end
        READ: begin
          if (mem_rd_addr[ADDR_W-1:0] == ADDR_W'(N-1)) begin
            mem_rd_en <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            mem_rd_addr[ADDR_W-1:0] <= mem_rd_addr[ADDR_W-1:0] + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
          end else if (stage_idx == 3'(STAGES-1)) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            result_bank <= 1'(STAGES % 2);
            state       <= DONE;
          end else begin
            stage_idx   <= stage_nxt;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= {stage_nxt[0], {ADDR_W{1'b0}}};
            shift_p0    <= shift_cfg[2*stage_nxt +: 2];
            state       <= READ;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- p0 -> p1: capture index, target bank and shift while the read is in flight
  // Metadata registers need no reset; vld_p1 qualifies them.
  always_ff @(posedge clk) begin
    idx_p1   <= mem_rd_addr[ADDR_W-1:0];
    bank_p1  <= ~mem_rd_addr[ADDR_W];
    shift_p1 <= shift_p0;
  end

  // ---- p1 -> write port: scale returned data and issue the write
  // Write strobe, address and data are outputs and clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      vld_p1    <= mem_rd_en;
      mem_wr_en <= vld_p1;
      if (vld_p1) begin
        mem_wr_addr <= {bank_p1, idx_p1};
        mem_wr_data <= scale(mem_rd_data, shift_p1);
      end
    end
  end

`ifdef SS_SAT_EN
  // Sticky overflow: cleared by an accepted start, set by any clamped write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (start_acc)
      ovf <= 1'b0;
    else if (vld_p1 && sat_hit(mem_rd_data, shift_p1))
      ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ss_stage_seq.sv
// tb_ss_stage_seq: directed table-driven bench for ss_stage_seq with a
// behavioural 1-cycle-latency ping-pong sample memory.
module tb_ss_stage_seq;

`ifdef SS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  cfg_shift;
  logic        busy;
  logic        done;
  logic [2:0]  stage_idx;
  logic        result_bank;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        ovf;

  ss_stage_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_shift  (cfg_shift),
    .busy       (busy),
    .done       (done),
    .stage_idx  (stage_idx),
    .result_bank(result_bank),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory: read data appears one cycle after the strobe
  logic [15:0] mem      [0:15];
  logic [15:0] init_mem [0:15];
  logic        load;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  typedef struct packed {
    logic [7:0][15:0] init;
    logic [5:0]       cfg;
    logic [7:0][15:0] fin;
    logic [15:0]      mid0;
    logic [15:0]      mid1;
    logic             ovf;
  } vec_t;

  vec_t vecs [0:4];

  int pass_cnt;
  int total_cnt;

  logic [63:0] exp_rd, exp_wr, exp_busy, exp_done;
  logic [63:0] rd_mask, wr_mask, busy_mask, done_mask, ovf_mask, rb_mask;
  logic [2:0]  stg_log [0:40];
  logic [15:0] snap [0:7];
  logic [15:0] mid0, mid1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs_flat();
    return 64'({busy, done, stage_idx, result_bank, mem_rd_en, mem_rd_addr,
                mem_wr_en, mem_wr_addr, mem_wr_data, ovf});
  endfunction

  task automatic reset_dut();
    start     = 1'b0;
    cfg_shift = 6'd0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_mem(input logic [7:0][15:0] w);
    for (int i = 0; i < 8; i++) begin
      init_mem[i]   = w[i];
      init_mem[8+i] = 16'hDEAD;
    end
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Start at cycle 0, then observe cycles 1..40; optional extra start pulses and reset
  task automatic run_block(input logic [5:0] cfg, input int x1, input int x2,
                           input logic [5:0] xcfg, input int rst_at);
    rd_mask = '0; wr_mask = '0; busy_mask = '0; done_mask = '0; ovf_mask = '0; rb_mask = '0;
    start     = 1'b1;
    cfg_shift = cfg;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      rd_mask[c]   = mem_rd_en;
      wr_mask[c]   = mem_wr_en;
      busy_mask[c] = busy;
      done_mask[c] = done;
      ovf_mask[c]  = ovf;
      rb_mask[c]   = result_bank;
      stg_log[c]   = stage_idx;
      if (c == 11) mid0 = mem[8];
      if (c == 21) mid1 = mem[0];
      if (c == 32) for (int k = 0; k < 8; k++) snap[k] = mem[8+k];
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_mid_block_outputs", outs_flat(), 64'd0);
      end
      if (rst_at > 0 && c == rst_at + 3) rst_n = 1'b1;
      start = (c == x1) || (c == x2);
      if (start) cfg_shift = xcfg;
    end
    start = 1'b0;
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_rd_cycles"},   rd_mask,   exp_rd);
    chk({tag, "_wr_cycles"},   wr_mask,   exp_wr);
    chk({tag, "_busy_cycles"}, busy_mask, exp_busy);
    chk({tag, "_done_cycles"}, done_mask, exp_done);
  endtask

  task automatic check_final(input string tag, input logic [7:0][15:0] fin);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_final_w%0d", tag, k), 64'(snap[k]), 64'(fin[k]));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    load      = 1'b0;
    start     = 1'b0;
    cfg_shift = 6'd0;
    rst_n     = 1'b1;

    exp_rd = '0; exp_wr = '0; exp_busy = '0; exp_done = '0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 8; i++) begin
        exp_rd[1 + s*10 + i] = 1'b1;
        exp_wr[3 + s*10 + i] = 1'b1;
      end
    for (int c = 1; c <= 30; c++) exp_busy[c] = 1'b1;
    exp_done[31] = 1'b1;

    // Vector table: {init bank0, cfg_shift, final bank1, bank1[0] after stage 0,
    //                bank0[0] after stage 1, ovf at done}
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    for (int i = 0; i < 8; i++) begin
      vecs[0].init[i] = 16'(i + 1);
      vecs[0].fin[i]  = 16'((i + 1) * 8);
      vecs[1].init[i] = 16'(i + 1);
      vecs[1].fin[i]  = 16'((i + 1) * 32);
    end
    vecs[0].cfg = 6'b01_01_01; vecs[0].mid0 = 16'd2; vecs[0].mid1 = 16'd4;
    vecs[1].cfg = 6'b11_00_10; vecs[1].mid0 = 16'd4; vecs[1].mid1 = 16'd4;

    vecs[2].cfg     = 6'b00_00_01;
    vecs[2].init[0] = 16'h4000; vecs[2].init[1] = 16'h0100; vecs[2].init[2] = 16'hFFFF;
    vecs[2].fin[0]  = SAT ? 16'h7FFF : 16'h8000;
    vecs[2].fin[1]  = 16'h0200; vecs[2].fin[2] = 16'hFFFE;
    vecs[2].mid0    = vecs[2].fin[0]; vecs[2].mid1 = vecs[2].fin[0];
    vecs[2].ovf     = SAT;

    vecs[3].cfg     = 6'b00_00_10;
    vecs[3].init[0] = 16'hC000; vecs[3].init[1] = 16'h1000; vecs[3].init[2] = 16'hFFFF;
    vecs[3].fin[0]  = SAT ? 16'h8000 : 16'h0000;
    vecs[3].fin[1]  = 16'h4000; vecs[3].fin[2] = 16'hFFFC;
    vecs[3].mid0    = vecs[3].fin[0]; vecs[3].mid1 = vecs[3].fin[0];
    vecs[3].ovf     = SAT;

    vecs[4].cfg     = 6'b11_11_11;
    vecs[4].init[0] = 16'hFFF0; vecs[4].init[1] = 16'h0001;
    vecs[4].fin[0]  = 16'hE000; vecs[4].fin[1] = 16'h0200;
    vecs[4].mid0    = 16'hFF80; vecs[4].mid1 = 16'hFC00;

    reset_dut();
    chk("reset_outputs", outs_flat(), 64'd0);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("v%0d", v);
      reset_dut();
      load_mem(vecs[v].init);
      run_block(vecs[v].cfg, -1, -1, 6'd0, -1);
      check_timing(tag);
      chk({tag, "_stage_c10"},    64'(stg_log[10]), 64'd0);
      chk({tag, "_stage_c11"},    64'(stg_log[11]), 64'd1);
      chk({tag, "_stage_c21"},    64'(stg_log[21]), 64'd2);
      chk({tag, "_result_bank"},  64'(rb_mask[31]), 64'd1);
      chk({tag, "_after_stage0"}, 64'(mid0), 64'(vecs[v].mid0));
      chk({tag, "_after_stage1"}, 64'(mid1), 64'(vecs[v].mid1));
      chk({tag, "_ovf_at_done"},  64'(ovf_mask[31]), 64'(vecs[v].ovf));
      check_final(tag, vecs[v].fin);
    end

    // start pulses while busy and in the DONE cycle are ignored
    reset_dut();
    load_mem(vecs[0].init);
    run_block(vecs[0].cfg, 5, 31, 6'b11_11_11, -1);
    check_timing("busy_start");
    check_final("busy_start", vecs[0].fin);

    // Asynchronous reset mid-block, then a clean block
    reset_dut();
    load_mem(vecs[0].init);
    run_block(vecs[0].cfg, -1, -1, 6'd0, 14);
    chk("rst_no_writes_after", wr_mask >> 15, 64'd0);
    chk("rst_no_busy_after",   busy_mask >> 15, 64'd0);
    chk("rst_no_done",         done_mask, 64'd0);
    load_mem(vecs[0].init);
    run_block(vecs[0].cfg, -1, -1, 6'd0, -1);
    check_timing("post_rst");
    check_final("post_rst", vecs[0].fin);

    // Back-to-back blocks after an overflowing one
    reset_dut();
    load_mem(vecs[2].init);
    run_block(vecs[2].cfg, 32, -1, vecs[2].cfg, -1);
    chk("b2b_done_c31",  64'(done_mask[31]), 64'd1);
    chk("b2b_ovf_c32",   64'(ovf_mask[32]), 64'(SAT));
    chk("b2b_rd_c32",    64'(rd_mask[32]), 64'd0);
    chk("b2b_rd_c33",    64'(rd_mask[33]), 64'd1);
    chk("b2b_busy_c33",  64'(busy_mask[33]), 64'd1);
    chk("b2b_stage_c33", 64'(stg_log[33]), 64'd0);
    chk("b2b_ovf_c33",   64'(ovf_mask[33]), 64'd0);
    check_final("b2b", vecs[2].fin);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
